// File: rtl/laser_centroid.sv
// Laser-spot centroid: classifies RGB565 pixels, accumulates per-frame coordinate sums,
// and divides them at frame end with two fixed-latency restoring dividers.
module laser_centroid #(
  parameter logic [4:0]  RED_MIN    = 5'd24,
  parameter logic [5:0]  GREEN_MAX  = 6'd20,
  parameter logic [16:0] MIN_PIXELS = 17'd4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [15:0] pixel_in,
  input  logic        data_valid_in,
  input  logic [8:0]  hcount_in,
  input  logic [7:0]  vcount_in,
  input  logic        frame_done_in,
  output logic [8:0]  x_out,
  output logic [7:0]  y_out,
  output logic        found_out,
  output logic        valid_out,
  output logic        busy_out,
  output logic        drop_out
);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [4:0]  bit_idx_r;
  logic [24:0] sum_x_r, sum_y_r, sum_x_s, sum_y_s;
  logic [16:0] cnt_r, cnt_s, snap_cnt_r;
  logic [24:0] quo_x_r, quo_y_r, rem_x_r, rem_y_r;
  logic [24:0] quo_x_s, quo_y_s, rem_x_s, rem_y_s;
  logic [24:0] add_x_s, add_y_s;
  logic [16:0] add_n_s;
  logic        is_laser_s, frame_end_s, overrun_s;
  logic [8:0]  x_r;
  logic [7:0]  y_r;
  logic        found_r, valid_r, busy_r, drop_r;

  // One restoring-division step: the dividend shifts out of quo's MSB while the
  // quotient bit shifts into its LSB, so after 25 steps quo holds the floor quotient.
  // A zero divisor just produces all-ones; that result is never reported.
  function automatic logic [49:0] div_step(input logic [24:0] rem,
                                           input logic [24:0] quo,
                                           input logic [16:0] dvs);
    logic [25:0] trial;
    logic        ge;
    trial = {rem, quo[24]};
    ge    = (trial >= {9'd0, dvs});
    if (ge) begin
      trial = trial - {9'd0, dvs};
    end else begin
      trial = trial;
    end
    return {trial[24:0], quo[23:0], ge};
  endfunction

  // Pixel classification and frame-end qualification
  always_comb begin
    is_laser_s  = data_valid_in
                  && (pixel_in[15:11] >= RED_MIN)
                  && (pixel_in[10:5] <= GREEN_MAX)
                  && (hcount_in < 9'd320)
                  && (vcount_in < 8'd240);
    add_x_s     = is_laser_s ? {16'd0, hcount_in} : 25'd0;
    add_y_s     = is_laser_s ? {17'd0, vcount_in} : 25'd0;
    add_n_s     = is_laser_s ? 17'd1 : 17'd0;
    frame_end_s = frame_done_in && (state_r == ACCUM);
    overrun_s   = frame_done_in && (state_r != ACCUM);
  end

  // Accumulator next-state: any frame_done clears (snapshot or discard)
  always_comb begin
    if (frame_done_in) begin
      sum_x_s = 25'd0;
      sum_y_s = 25'd0;
      cnt_s   = 17'd0;
    end else begin
      sum_x_s = sum_x_r + add_x_s;
      sum_y_s = sum_y_r + add_y_s;
      cnt_s   = cnt_r + add_n_s;
    end
  end

  // FSM next-state and divider datapath
  always_comb begin
    state_s = state_r;
    quo_x_s = quo_x_r;
    quo_y_s = quo_y_r;
    rem_x_s = rem_x_r;
    rem_y_s = rem_y_r;
    case (state_r)
      ACCUM: begin
        if (frame_done_in) begin
          state_s = DIVIDE;
        end else begin
          state_s = ACCUM;
        end
      end
      DIVIDE: begin
        {rem_x_s, quo_x_s} = div_step(rem_x_r, quo_x_r, snap_cnt_r);
        {rem_y_s, quo_y_s} = div_step(rem_y_r, quo_y_r, snap_cnt_r);
        if (bit_idx_r == 5'd0) begin
          state_s = REPORT;
        end else begin
          state_s = DIVIDE;
        end
      end
      REPORT: begin
        state_s = ACCUM;
      end
      default: begin
        state_s = ACCUM;
      end
    endcase
  end

  // Accumulator registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sum_x_r <= 25'd0;
      sum_y_r <= 25'd0;
      cnt_r   <= 17'd0;
    end else begin
      sum_x_r <= sum_x_s;
      sum_y_r <= sum_y_s;
      cnt_r   <= cnt_s;
    end
  end

  // State, bit index and divider registers; the snapshot includes a same-cycle pixel
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r    <= ACCUM;
      bit_idx_r  <= 5'd0;
      snap_cnt_r <= 17'd0;
      quo_x_r    <= 25'd0;
      quo_y_r    <= 25'd0;
      rem_x_r    <= 25'd0;
      rem_y_r    <= 25'd0;
    end else begin
      state_r <= state_s;
      if (frame_end_s) begin
        quo_x_r    <= sum_x_r + add_x_s;
        quo_y_r    <= sum_y_r + add_y_s;
        rem_x_r    <= 25'd0;
        rem_y_r    <= 25'd0;
        snap_cnt_r <= cnt_r + add_n_s;
        bit_idx_r  <= 5'd24;
      end else begin
        quo_x_r    <= quo_x_s;
        quo_y_r    <= quo_y_s;
        rem_x_r    <= rem_x_s;
        rem_y_r    <= rem_y_s;
        snap_cnt_r <= snap_cnt_r;
        if ((state_r == DIVIDE) && (bit_idx_r != 5'd0)) begin
          bit_idx_r <= bit_idx_r - 5'd1;
        end else begin
          bit_idx_r <= bit_idx_r;
        end
      end
    end
  end

  // Registered result, status and overrun outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x_r     <= 9'd0;
      y_r     <= 8'd0;
      found_r <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      valid_r <= (state_r == REPORT);
      busy_r  <= (state_s != ACCUM);
      drop_r  <= overrun_s;
      if (state_r == REPORT) begin
        if (snap_cnt_r >= MIN_PIXELS) begin
          x_r     <= quo_x_r[8:0];
          y_r     <= quo_y_r[7:0];
          found_r <= 1'b1;
        end else begin
          x_r     <= x_r;
          y_r     <= y_r;
          found_r <= 1'b0;
        end
      end else begin
        x_r     <= x_r;
        y_r     <= y_r;
        found_r <= found_r;
      end
    end
  end

  assign x_out     = x_r;
  assign y_out     = y_r;
  assign found_out = found_r;
  assign valid_out = valid_r;
  assign busy_out  = busy_r;
  assign drop_out  = drop_r;

endmodule

// File: tb/tb_laser_centroid.sv
// Bench for laser_centroid: two instances (MIN_PIXELS 1 and 4) checked every cycle against
// a frame-level arithmetic model, plus hand-computed checks of directed scenarios.
module tb_laser_centroid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pixel = 16'd0;
  logic        dv = 1'b0;
  logic [8:0]  hc = 9'd0;
  logic [7:0]  vc = 8'd0;
  logic        fd = 1'b0;

  logic [8:0] x1, x4;
  logic [7:0] y1, y4;
  logic       f1, f4, v1, v4, b1, b4, d1, d4;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  laser_centroid #(.MIN_PIXELS(17'd1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .pixel_in(pixel), .data_valid_in(dv),
    .hcount_in(hc), .vcount_in(vc), .frame_done_in(fd),
    .x_out(x1), .y_out(y1), .found_out(f1), .valid_out(v1), .busy_out(b1), .drop_out(d1));

  laser_centroid dut4 (
    .clk_in(clk), .rst_n_in(rst_n), .pixel_in(pixel), .data_valid_in(dv),
    .hcount_in(hc), .vcount_in(vc), .frame_done_in(fd),
    .x_out(x4), .y_out(y4), .found_out(f4), .valid_out(v4), .busy_out(b4), .drop_out(d4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int acc_x = 0, acc_y = 0, acc_n = 0;
  int snap_x = 0, snap_y = 0, snap_n = 0;
  int edges_left = 0;
  int e_x1 = 0, e_y1 = 0, e_f1 = 0, e_x4 = 0, e_y4 = 0, e_f4 = 0;
  int e_valid = 0, e_busy = 0, e_drop = 0;

  always @(posedge clk) begin
    bit busy_pre, lz;
    if (!rst_n) begin
      acc_x = 0; acc_y = 0; acc_n = 0; snap_x = 0; snap_y = 0; snap_n = 0;
      edges_left = 0;
      e_x1 = 0; e_y1 = 0; e_f1 = 0; e_x4 = 0; e_y4 = 0; e_f4 = 0;
      e_valid = 0; e_busy = 0; e_drop = 0;
    end else begin
      busy_pre = (edges_left > 0);
      lz = dv && (int'(pixel[15:11]) >= 24) && (int'(pixel[10:5]) <= 20)
              && (int'(hc) < 320) && (int'(vc) < 240);
      e_drop  = (fd && busy_pre) ? 1 : 0;
      e_valid = 0;
      if (fd && !busy_pre) begin
        snap_x = acc_x + (lz ? int'(hc) : 0);
        snap_y = acc_y + (lz ? int'(vc) : 0);
        snap_n = acc_n + (lz ? 1 : 0);
        acc_x = 0; acc_y = 0; acc_n = 0;
        edges_left = 26;
      end else if (fd) begin
        acc_x = 0; acc_y = 0; acc_n = 0;
      end else if (lz) begin
        acc_x += int'(hc); acc_y += int'(vc); acc_n += 1;
      end
      if (busy_pre) begin
        edges_left--;
        if (edges_left == 0) begin
          e_valid = 1;
          if (snap_n >= 1) begin e_x1 = snap_x / snap_n; e_y1 = snap_y / snap_n; e_f1 = 1; end
          else e_f1 = 0;
          if (snap_n >= 4) begin e_x4 = snap_x / snap_n; e_y4 = snap_y / snap_n; e_f4 = 1; end
          else e_f4 = 0;
        end
      end
      e_busy = (edges_left > 0) ? 1 : 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n && run_chk) begin
      chk("x1", {23'd0, x1}, e_x1);     chk("y1", {24'd0, y1}, e_y1);
      chk("found1", {31'd0, f1}, e_f1); chk("valid1", {31'd0, v1}, e_valid);
      chk("busy1", {31'd0, b1}, e_busy); chk("drop1", {31'd0, d1}, e_drop);
      chk("x4", {23'd0, x4}, e_x4);     chk("y4", {24'd0, y4}, e_y4);
      chk("found4", {31'd0, f4}, e_f4); chk("valid4", {31'd0, v4}, e_valid);
      chk("busy4", {31'd0, b4}, e_busy); chk("drop4", {31'd0, d4}, e_drop);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [15:0] p, input logic d, input int h, input int v, input logic f);
    @(negedge clk);
    pixel = p; dv = d; hc = 9'(h); vc = 8'(v); fd = f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(16'd0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic laser(input int h, input int v);
    drive(16'hF800, 1'b1, h, v, 1'b0);
  endtask

  // Wait (bounded) for the result strobe; returns negedges counted since the frame_done cycle
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      pixel = 16'd0; dv = 1'b0; hc = 9'd0; vc = 8'd0; fd = 1'b0;
      if (v1 === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic end_frame(output int lat);
    drive(16'd0, 1'b0, 0, 0, 1'b1);
    wait_valid(lat);
  endtask

  initial begin
    int lat;
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    run_chk = 1'b1;
    chk("reset_valid", {31'd0, v1}, 32'd0);
    chk("reset_busy", {31'd0, b1}, 32'd0);
    chk("reset_x", {23'd0, x1}, 32'd0);
    idle(2);

    // Single pixel, latency
    laser(100, 50); idle(2);
    end_frame(lat);
    chk("latency", lat, 32'd27);
    chk("t1_x", {23'd0, x1}, 32'd100); chk("t1_y", {24'd0, y1}, 32'd50);
    chk("t1_found", {31'd0, f1}, 32'd1); chk("t1_found4", {31'd0, f4}, 32'd0);

    // 3x3 block plus non-laser pixels
    drive(16'h07E0, 1'b1, 50, 50, 1'b0);
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) laser(200 + dx, 120 + dy);
    drive(16'hFFFF, 1'b1, 60, 60, 1'b0);
    end_frame(lat);
    chk("t2_x4", {23'd0, x4}, 32'd200); chk("t2_y4", {24'd0, y4}, 32'd120);
    chk("t2_found4", {31'd0, f4}, 32'd1);

    // Floor and same-cycle pixel
    laser(10, 5); laser(13, 5);
    end_frame(lat);
    chk("t3_x", {23'd0, x1}, 32'd11); chk("t3_y", {24'd0, y1}, 32'd5);
    laser(10, 5);
    drive(16'hF800, 1'b1, 13, 5, 1'b1);
    wait_valid(lat);
    chk("t3b_x", {23'd0, x1}, 32'd11);
    chk("t3b_lat", lat, 32'd27);

    // Below MIN_PIXELS retains previous result; empty frame too
    laser(1, 1); laser(2, 2); laser(3, 3);
    end_frame(lat);
    chk("t4_found4", {31'd0, f4}, 32'd0);
    chk("t4_x4", {23'd0, x4}, 32'd200); chk("t4_y4", {24'd0, y4}, 32'd120);
    chk("t4_x1", {23'd0, x1}, 32'd2);
    end_frame(lat);
    chk("t4e_found1", {31'd0, f1}, 32'd0); chk("t4e_x1", {23'd0, x1}, 32'd2);
    chk("t4e_found4", {31'd0, f4}, 32'd0); chk("t4e_y4", {24'd0, y4}, 32'd120);

    // Overrun
    laser(30, 40);
    drive(16'hF800, 1'b1, 34, 44, 1'b1);
    for (int k = 1; k <= 9; k++) laser(300, 200);
    drive(16'hF800, 1'b1, 300, 200, 1'b1);
    @(negedge clk);
    pixel = 16'd0; dv = 1'b0; fd = 1'b0;
    chk("t5_drop", {31'd0, d1}, 32'd1);
    wait_valid(lat);
    chk("t5_x", {23'd0, x1}, 32'd32); chk("t5_y", {24'd0, y1}, 32'd42);
    idle(2);
    laser(5, 6);
    end_frame(lat);
    chk("t5b_x", {23'd0, x1}, 32'd5); chk("t5b_y", {24'd0, y1}, 32'd6);

    // Reset in the middle of a division
    laser(7, 8);
    drive(16'd0, 1'b0, 0, 0, 1'b1);
    idle(12);
    chk("t6_busy", {31'd0, b1}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_x", {23'd0, x1}, 32'd0); chk("t6_y", {24'd0, y1}, 32'd0);
    chk("t6_found", {31'd0, f1}, 32'd0); chk("t6_busy0", {31'd0, b1}, 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(40);
    laser(7, 8); laser(9, 10);
    end_frame(lat);
    chk("t6b_x", {23'd0, x1}, 32'd8); chk("t6b_y", {24'd0, y1}, 32'd9);

    // Randomized frames, including early frame_done overruns
    for (int f = 0; f < 30; f++) begin
      int len = int'($urandom_range(5, 60));
      for (int c = 0; c < len; c++) begin
        logic [15:0] p;
        if ($urandom_range(0, 1) == 0)
          p = {5'($urandom_range(20, 31)), 6'($urandom_range(0, 30)), 5'($urandom)};
        else
          p = 16'($urandom);
        drive(p, 1'($urandom_range(0, 9) < 6), int'($urandom_range(0, 330)),
              int'($urandom_range(0, 250)), 1'b0);
      end
      drive(16'hF800, 1'($urandom_range(0, 1)), int'($urandom_range(0, 319)),
            int'($urandom_range(0, 239)), 1'b1);
      idle(int'($urandom_range(0, 35)));
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
